// File: rtl/midi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// midi_pkg: shared receiver state encoding, default rates and bit timing
// Revision: 1.0
// ----------------------------------------------------------------------------
package midi_pkg;

  localparam int DEF_CLK_FREQ   = 50_000_000;
  localparam int DEF_BAUD       = 31_250;
  localparam int DEF_FIFO_DEPTH = 16;

  localparam int CLKS_PER_BIT = DEF_CLK_FREQ / DEF_BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/midi_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// midi_fifo: first-word-fall-through FIFO, head byte visible combinationally
// Revision: 1.0
// ----------------------------------------------------------------------------
module midi_fifo
  import midi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end

endmodule
`default_nettype wire

// File: rtl/midi_top.sv
`default_nettype none
// ----------------------------------------------------------------------------
// midi_top: MIDI 8N1 serial receiver feeding a byte FIFO
// Revision: 1.0
// ----------------------------------------------------------------------------
module midi_top
  import midi_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic [7:0] dout,
  input  logic       rd_en,
  output logic       empty
);

  localparam int BIT_CLKS  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CNT_W     = $clog2(BIT_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLKS - 1);

  logic sync_q1;
  logic sync_q2;
  logic din_prev;
  logic din_fall;

  // din_prev lets the receiver arm only on a true falling edge, so a low
  // stop bit cannot be mistaken for the next start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1  <= 1'b1;
      sync_q2  <= 1'b1;
      din_prev <= 1'b1;
    end else begin
      sync_q1  <= din;
      sync_q2  <= sync_q1;
      din_prev <= sync_q2;
    end
  end

  assign din_fall = din_prev & ~sync_q2;

  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic             frame_ok;
  logic             fifo_wr;
  logic             full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    frame_ok    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (din_fall) begin
          bit_idx_nxt = '0;
          state_nxt   = START;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = sync_q2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = sync_q2;
          bit_idx_nxt        = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          frame_ok  = sync_q2;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_wr = frame_ok & (~full | (rd_en & ~empty));

  midi_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (fifo_wr),
    .din   (shift),
    .rd_en (rd_en),
    .dout  (dout),
    .empty (empty),
    .full  (full)
  );

endmodule
`default_nettype wire

// File: tb/tb_midi_top.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_midi_top: self-checking bench for the MIDI receiver and byte FIFO
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_midi_top;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic       accept;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       empty;

  int checks = 0;
  int passed = 0;

  logic [7:0] model_q[$];
  vec_t       vecs[8];
  logic [7:0] stream[11];
  logic [7:0] want_b;
  logic [7:0] rnd_b;
  logic       rnd_stop;
  bit         done;
  int         budget;

  midi_top #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout),
    .rd_en (rd_en),
    .empty (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %02h required %02h", name, act, want);
  endtask

  // Reference model: a bounded in-order queue of bytes whose frames end in a valid stop bit.
  task automatic model_push(input logic [7:0] d, input logic stop);
    if (stop && model_q.size() < DEPTH) model_q.push_back(d);
  endtask

  task automatic drive_bit(input logic b);
    din = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    if (!stop) drive_bit(1'b1);
  endtask

  task automatic pop_check(input string name, input logic [7:0] want);
    check({name, "_nonempty"}, {7'd0, empty}, 8'd0);
    check(name, dout, want);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h90, 1'b1, 1'b1};
    vecs[1] = '{8'h45, 1'b0, 1'b0};
    vecs[2] = '{8'h12, 1'b1, 1'b1};
    vecs[3] = '{8'h3C, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 1'b1};
    vecs[6] = '{8'hA5, 1'b0, 1'b0};
    vecs[7] = '{8'h5A, 1'b1, 1'b1};
    stream  = '{8'h90, 8'h3C, 8'h64, 8'h80, 8'h3C, 8'h00,
                8'hB0, 8'h07, 8'h7F, 8'hC0, 8'h05};

    repeat (3) @(negedge clk);
    check("reset_empty", {7'd0, empty}, 8'd1);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_empty", {7'd0, empty}, 8'd1);

    // Single byte: empty must fall no later than 3 clocks after stop-bit mid.
    fork
      send_frame(8'h90, 1'b1);
      begin
        repeat (CPB * 9 + CPB / 2) @(negedge clk);
        check("empty_at_stop_mid", {7'd0, empty}, 8'd1);
        repeat (3) @(negedge clk);
        check("empty_3clk_after_stop_mid", {7'd0, empty}, 8'd0);
      end
    join
    pop_check("single_90", 8'h90);
    check("single_popped_empty", {7'd0, empty}, 8'd1);

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].data, vecs[v].stop);
      repeat (4) @(negedge clk);
      check("vec_empty", {7'd0, empty}, {7'd0, ~vecs[v].accept});
      if (vecs[v].accept) pop_check("vec_dout", vecs[v].data);
      check("vec_after_empty", {7'd0, empty}, 8'd1);
    end

    // Short low glitch must be rejected.
    din = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    din = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_no_byte", {7'd0, empty}, 8'd1);
    send_frame(8'h7F, 1'b1);
    repeat (2) @(negedge clk);
    pop_check("after_glitch_7F", 8'h7F);

    // Back-to-back stream, then random frames, popped as soon as available.
    model_q.delete();
    done   = 1'b0;
    budget = 40000;
    fork
      begin
        for (int i = 0; i < 11; i++) begin
          model_push(stream[i], 1'b1);
          send_frame(stream[i], 1'b1);
        end
        for (int i = 0; i < 40; i++) begin
          rnd_b    = 8'($urandom);
          rnd_stop = ($urandom_range(0, 4) != 0);
          model_push(rnd_b, rnd_stop);
          send_frame(rnd_b, rnd_stop);
        end
        done = 1'b1;
      end
      begin
        while (!(done && model_q.size() == 0) && budget > 0) begin
          @(negedge clk);
          budget--;
          rd_en = 1'b0;
          if (!empty) begin
            if (model_q.size() == 0) begin
              checks++;
              $display("FAIL stream_extra: got %02h required no byte", dout);
            end else begin
              want_b = model_q.pop_front();
              check("stream_byte", dout, want_b);
            end
            rd_en = 1'b1;
          end
        end
        @(negedge clk);
        rd_en = 1'b0;
        if (budget == 0) begin
          checks++;
          $display("FAIL stream_timeout: got %0d bytes outstanding required 0", model_q.size());
        end
      end
    join
    repeat (2 * CPB) @(negedge clk);
    check("stream_drained", {7'd0, empty}, 8'd1);

    // Overflow: 17 writes with no reads keep the first 16.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_q.delete();
    for (int i = 0; i < 17; i++) begin
      model_push(8'(i), 1'b1);
      send_frame(8'(i), 1'b1);
    end
    repeat (4) @(negedge clk);
    while (model_q.size() > 0) begin
      want_b = model_q.pop_front();
      pop_check("ovf_pop", want_b);
    end
    check("ovf_empty", {7'd0, empty}, 8'd1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("rd_while_empty", {7'd0, empty}, 8'd1);
    send_frame(8'h55, 1'b1);
    repeat (2) @(negedge clk);
    pop_check("after_empty_rd_55", 8'h55);
    check("after_empty_rd_empty", {7'd0, empty}, 8'd1);

    // Reset in the middle of data bit 4 aborts the frame and flushes the FIFO.
    send_frame(8'h11, 1'b1);
    repeat (2) @(negedge clk);
    check("pre_abort_loaded", {7'd0, empty}, 8'd0);
    rnd_b = 8'h33;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rnd_b[i]);
    din = rnd_b[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_empty_immediate", {7'd0, empty}, 8'd1);
    din = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("abort_no_write", {7'd0, empty}, 8'd1);
    send_frame(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    pop_check("after_abort_A5", 8'hA5);
    check("after_abort_empty", {7'd0, empty}, 8'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
